// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous PWM input
// in CLK cycles, recovers an 8-bit duty and flags stuck-low/stuck-high through an idle timeout.
module pwm_capture #(
  parameter int CNT_W          = 16,
  parameter int NOMINAL_PERIOD = 256,
  parameter int TIMEOUT        = 1024
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic [CNT_W-1:0] PERIOD,
  output logic [7:0]       DUTY_CYCLE,
  output logic             VALID,
  output logic             STUCK,
  output logic             PERIOD_ERR
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_NOM   = CNT_W'(NOMINAL_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_255   = CNT_W'(255);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]  r_hi_cnt, r_per_cnt, w_hi_nxt, w_per_nxt, w_hi_inc, w_per_inc;
  logic [IDLE_W-1:0] r_idle;
  logic [CNT_W-1:0]  r_high_time, r_period;
  logic [7:0]        r_duty, w_hi_sat8;
  logic              r_valid, r_stuck, r_period_err;
  logic              w_rise, w_fall, w_edge, w_timeout, w_close;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_fall    = ~r_sync2 & r_prev;
  assign w_edge    = w_rise | w_fall;
  // A detected edge always resets the idle count, so it can never coincide with expiry
  assign w_timeout = ~w_edge && (r_idle == IDLE_LAST);

  assign w_hi_inc  = (r_hi_cnt  == CNT_MAX) ? r_hi_cnt  : r_hi_cnt  + CNT_ONE;
  assign w_per_inc = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_ONE;
  assign w_hi_sat8 = (r_hi_cnt > CNT_255) ? 8'hFF : r_hi_cnt[7:0];

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi_cnt;
    w_per_nxt   = r_per_cnt;
    w_close     = 1'b0;
    if (w_timeout) begin
      w_state_nxt = WAIT_RISE;
    end else begin
      case (r_state)
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
            w_hi_nxt    = CNT_ONE;
            w_per_nxt   = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          w_per_nxt = w_per_inc;
          if (w_fall) w_state_nxt = MEAS_LOW;
          else        w_hi_nxt    = w_hi_inc;
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_close     = 1'b1;
            w_state_nxt = MEAS_HIGH;
            w_hi_nxt    = CNT_ONE;
            w_per_nxt   = CNT_ONE;
          end else begin
            w_per_nxt = w_per_inc;
          end
        end
        default: w_state_nxt = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_state      <= WAIT_RISE;
      r_hi_cnt     <= '0;
      r_per_cnt    <= '0;
      r_idle       <= '0;
      r_high_time  <= '0;
      r_period     <= '0;
      r_duty       <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
      r_period_err <= 1'b0;
    end else begin
      r_sync1   <= PWM_IN;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_state   <= w_state_nxt;
      r_hi_cnt  <= w_hi_nxt;
      r_per_cnt <= w_per_nxt;
      r_idle    <= (w_edge || w_timeout) ? '0 : r_idle + 1'b1;
      r_valid   <= w_close | w_timeout;

      if (w_edge)         r_stuck <= 1'b0;
      else if (w_timeout) r_stuck <= 1'b1;

      if (w_close) begin
        r_period     <= r_per_cnt;
        r_high_time  <= r_hi_cnt;
        r_duty       <= w_hi_sat8;
        r_period_err <= (r_per_cnt != CNT_NOM);
      end else if (w_timeout) begin
        r_period     <= '0;
        r_period_err <= 1'b0;
        // Stuck high reports the high time accumulated so far; stuck low reads as 0%
        if (r_sync2) begin
          r_high_time <= r_hi_cnt;
          r_duty      <= 8'hFF;
        end else begin
          r_high_time <= '0;
          r_duty      <= 8'h00;
        end
      end
    end
  end

  assign HIGH_TIME  = r_high_time;
  assign PERIOD     = r_period;
  assign DUTY_CYCLE = r_duty;
  assign VALID      = r_valid;
  assign STUCK      = r_stuck;
  assign PERIOD_ERR = r_period_err;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: event-level timing model checked every cycle, plus
// directed scenarios with literal expectations on the reported measurements.
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int NOM   = 256;
  localparam int TMO   = 1024;
  localparam int CMAX  = 65535;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             PWM_IN = 1'b0;
  logic [CNT_W-1:0] HIGH_TIME, PERIOD;
  logic [7:0]       DUTY_CYCLE;
  logic             VALID, STUCK, PERIOD_ERR;

  pwm_capture #(.CNT_W(CNT_W), .NOMINAL_PERIOD(NOM), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset), .PWM_IN(PWM_IN),
    .HIGH_TIME(HIGH_TIME), .PERIOD(PERIOD), .DUTY_CYCLE(DUTY_CYCLE),
    .VALID(VALID), .STUCK(STUCK), .PERIOD_ERR(PERIOD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int t; int high; int per; int duty; int perr; int stuck;
  } ev_t;
  ev_t ev_q[$];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Model: detected level is the input two samples old; measurements are
  // differences of detected edge times, timeouts are TMO cycles after the last edge.
  bit h0, h1, h2;
  int mt = 0, t_edge = 0, t_rise = 0, t_fall = 0, last_sh = 0;
  bit armed = 1'b0, fseen = 1'b0;
  int e_high = 0, e_per = 0, e_duty = 0;
  bit e_valid = 1'b0, e_stuck = 1'b0, e_perr = 1'b0;

  always @(posedge CLK) begin
    bit cur, prv;
    int hi;
    mt++;
    cur = h1;
    prv = h2;
    if (reset) begin
      h0 = 0; h1 = 0; h2 = 0;
      armed = 0; fseen = 0; t_edge = mt; last_sh = 0;
      e_high = 0; e_per = 0; e_duty = 0; e_valid = 0; e_stuck = 0; e_perr = 0;
    end else begin
      h2 = h1; h1 = h0; h0 = PWM_IN;
      e_valid = 0;
      if (cur && !prv) begin
        if (armed && fseen) begin
          e_valid = 1;
          e_per   = sat(mt - t_rise);
          e_high  = sat(t_fall - t_rise);
          e_duty  = (e_high > 255) ? 255 : e_high;
          e_perr  = (e_per != NOM);
        end
        armed = 1; fseen = 0; t_rise = mt; t_edge = mt; e_stuck = 0;
      end else if (!cur && prv) begin
        if (armed) begin fseen = 1; t_fall = mt; end
        t_edge = mt; e_stuck = 0;
      end else if (mt - t_edge == TMO) begin
        e_valid = 1; e_stuck = 1; e_per = 0; e_perr = 0;
        if (cur) begin
          hi = (armed && !fseen) ? sat(mt - t_rise) : last_sh;
          last_sh = hi; e_high = hi; e_duty = 255;
        end else begin
          e_high = 0; e_duty = 0;
        end
        armed = 0; t_edge = mt;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_vec++;
      if (VALID !== e_valid || STUCK !== e_stuck || PERIOD_ERR !== e_perr ||
          HIGH_TIME !== CNT_W'(e_high) || PERIOD !== CNT_W'(e_per) || DUTY_CYCLE !== 8'(e_duty)) begin
        n_bad++;
        $display("FAIL model cyc=%0d got v=%0b s=%0b e=%0b h=%0d p=%0d d=%0d expected v=%0b s=%0b e=%0b h=%0d p=%0d d=%0d",
                 cyc, VALID, STUCK, PERIOD_ERR, HIGH_TIME, PERIOD, DUTY_CYCLE,
                 e_valid, e_stuck, e_perr, e_high, e_per, e_duty);
      end
      if (VALID === 1'b1)
        ev_q.push_back('{cyc, int'(HIGH_TIME), int'(PERIOD), int'(DUTY_CYCLE),
                         int'(PERIOD_ERR), int'(STUCK)});
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pwm(input int hi, input int per, input int n);
    for (int p = 0; p < n; p++) begin
      PWM_IN = 1'b1; repeat (hi) @(negedge CLK);
      PWM_IN = 1'b0; repeat (per - hi) @(negedge CLK);
    end
  endtask

  task automatic pulse_reset(output int t_rst);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    t_rst = cyc;
  endtask

  initial begin
    int n0, t_rst, bad, nst, ist;
    reset = 1'b1; PWM_IN = 1'b0;
    @(negedge CLK); @(negedge CLK);
    reset = 1'b0; chk_en = 1'b1;
    chk("rst_high", int'(HIGH_TIME), 0);
    chk("rst_period", int'(PERIOD), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_stuck", int'(STUCK), 0);

    // duty 64, nominal period
    n0 = ev_q.size();
    pwm(64, 256, 5);
    chk("d64_count", ev_q.size() - n0, 4);
    chk("d64_high", ev_q[$].high, 64);
    chk("d64_period", ev_q[$].per, 256);
    chk("d64_duty", ev_q[$].duty, 64);
    chk("d64_perr", ev_q[$].perr, 0);
    chk("d64_spacing", ev_q[$].t - ev_q[$-1].t, 256);

    // duty step 64 -> 200
    n0 = ev_q.size();
    pwm(200, 256, 3);
    bad = 0;
    for (int i = n0; i < ev_q.size(); i++)
      if (ev_q[i].high != 64 && ev_q[i].high != 200) bad++;
    chk("step_count", ev_q.size() - n0, 3);
    chk("step_no_intermediate", bad, 0);
    chk("step_high", ev_q[$].high, 200);

    // stuck low from reset, then duty 10
    pulse_reset(t_rst);
    n0 = ev_q.size();
    repeat (2100) @(negedge CLK);
    chk("low_count", ev_q.size() - n0, 2);
    chk("low_first_time", ev_q[n0].t - t_rst, TMO);
    chk("low_repeat", ev_q[n0+1].t - ev_q[n0].t, TMO);
    chk("low_duty", ev_q[n0].duty, 0);
    chk("low_stuck", ev_q[n0].stuck, 1);
    chk("low_period", ev_q[n0].per, 0);
    chk("low_stuck_level", int'(STUCK), 1);
    n0 = ev_q.size();
    PWM_IN = 1'b1; repeat (4) @(negedge CLK);
    chk("low_stuck_clear", int'(STUCK), 0);
    repeat (6) @(negedge CLK);
    PWM_IN = 1'b0; repeat (246) @(negedge CLK);
    pwm(10, 256, 2);
    chk("d10_count", ev_q.size() - n0, 2);
    chk("d10_high", ev_q[$].high, 10);
    chk("d10_period", ev_q[$].per, 256);

    // stuck high for 2000 cycles, then fresh measurement
    n0 = ev_q.size();
    PWM_IN = 1'b1; repeat (2000) @(negedge CLK);
    PWM_IN = 1'b0; repeat (100) @(negedge CLK);
    pwm(64, 256, 2);
    nst = 0; ist = 0;
    for (int i = n0; i < ev_q.size(); i++)
      if (ev_q[i].stuck == 1) begin nst++; ist = i; end
    chk("high_stuck_count", nst, 1);
    chk("high_stuck_duty", ev_q[ist].duty, 255);
    chk("high_stuck_high", ev_q[ist].high, TMO);
    chk("high_stuck_period", ev_q[ist].per, 0);
    chk("high_after_count", ev_q.size() - 1 - ist, 1);
    chk("high_after_duty", ev_q[$].duty, 64);
    chk("high_after_period", ev_q[$].per, 256);

    // off-nominal period
    pwm(150, 300, 3);
    chk("p300_high", ev_q[$].high, 150);
    chk("p300_period", ev_q[$].per, 300);
    chk("p300_duty", ev_q[$].duty, 150);
    chk("p300_perr", ev_q[$].perr, 1);

    // reset in the low phase of a period
    pwm(64, 256, 1);
    PWM_IN = 1'b1; repeat (64) @(negedge CLK);
    PWM_IN = 1'b0; repeat (100) @(negedge CLK);
    pulse_reset(t_rst);
    n0 = ev_q.size();
    chk("mid_rst_high", int'(HIGH_TIME), 0);
    chk("mid_rst_period", int'(PERIOD), 0);
    chk("mid_rst_duty", int'(DUTY_CYCLE), 0);
    chk("mid_rst_perr", int'(PERIOD_ERR), 0);
    chk("mid_rst_valid", int'(VALID), 0);
    repeat (91) @(negedge CLK);
    pwm(64, 256, 3);
    chk("mid_rst_count", ev_q.size() - n0, 2);
    chk("mid_rst_gap", int'(ev_q[n0].t - t_rst >= 347), 1);
    chk("mid_rst_high_after", ev_q[n0].high, 64);
    chk("mid_rst_period_after", ev_q[n0].per, 256);

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
